step_sequencer: RTL and testbench
=================================

# step_sequencer

Step/direction pulse sequencer that drives one SCARA joint's stepper driver. It accepts a move command (direction, step count, step period) over a valid/ready handshake and emits exactly that many fixed-width step pulses at the commanded period. It signals completion, and an external abort ends the move early. Internally it sequences a period counter and a remaining-steps counter; it sits between the motion-command layer and the driver output pins, one instance per joint.

## Interface

- CNT_WIDTH, 32, width of step period (clock cycles per step)
- STEP_WIDTH, 16, width of step count
- PULSE_WIDTH, 4, cycles the step output is held high per step (≥1)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_dir  in  1  direction for the move (1 = positive)
- cmd_steps  in  STEP_WIDTH  number of steps to issue
- cmd_period  in  CNT_WIDTH  cycles per step
- abort  in  1  terminate current move
- step  out  1  step pulse to driver, registered
- dir  out  1  direction to driver, registered, held between moves
- busy  out  1  move in progress (RUN or DONE)
- done  out  1  one-cycle pulse at end of move (normal or aborted)
- steps_left  out  STEP_WIDTH  remaining steps, including the one in progress
- position  out  32  signed joint position in steps (see Configuration)

## Operation

- States: IDLE, RUN, DONE. Reset forces IDLE and sets every output to 0 (cmd_ready is 0 during reset, 1 in the first IDLE cycle).
- cmd_ready = 1 only in IDLE. A transfer occurs on an edge where cmd_valid && cmd_ready.
- Transfer with cmd_steps ≠ 0:
  - latch dir and steps_left = cmd_steps
  - latch effective period P = max(cmd_period, PULSE_WIDTH+1)
  - clear the period counter cnt to 0
  - go to RUN
- Transfer with cmd_steps = 0: go directly to DONE. No step pulse is issued, and dir is still updated.
- RUN:
  - step = 1 while cnt < PULSE_WIDTH, else 0.
  - cnt increments each cycle. At cnt = P−1 it wraps to 0 and steps_left decrements.
  - When steps_left decrements from 1 to 0, go to DONE.
- DONE lasts exactly one cycle: done=1, step=0. Then IDLE.
- abort=1 in RUN: on the next edge step=0 and state moves to DONE. A pulse in progress is truncated. steps_left freezes, including the current partial step. abort in IDLE or DONE is ignored.
- abort and the final wrap in the same cycle: treated as normal completion, so steps_left=0.
- cmd_* inputs are ignored outside IDLE. Latched values are stable for the whole move.
- busy = (state ≠ IDLE).

## Timing

- Transfer on edge k: busy=1, dir valid and step=1 from edge k+1 (first step rises 1 cycle after acceptance).
- Each step occupies exactly P cycles: rising edges of step are P cycles apart, and each pulse is high for PULSE_WIDTH cycles.
- A move of N steps: RUN spans N·P cycles, done is high in cycle N·P+1 after acceptance, and cmd_ready returns the cycle after.
- Back-to-back commands: minimum gap between a move's last pulse period and the next move's first step is 2 cycles (DONE + IDLE).
- Abort asserted in cycle j of RUN: step=0 and done=1 in cycle j+1, cmd_ready=1 in j+2.
- Reset asserted mid-move: on the next edge step=0, busy=0 and position=0. There is no done pulse.

## Configuration

- Macro STEP_SEQ_POSITION_EN.
- Defined: position is a 32-bit signed accumulator that changes on the cycle each step pulse rises (cnt = 0 in RUN): +1 if dir=1, −1 if dir=0. It wraps two's-complement at ±2^31, is cleared only by reset, and abort does not undo the current step.
- Not defined: no accumulator is built and position is tied to 0.

## Test plan

- Reset, then idle 5 cycles -> step=0, busy=0, done=0, steps_left=0, position=0, cmd_ready=1.
- cmd_steps=3, cmd_period=10, cmd_dir=1 -> 3 pulses each 4 cycles high, 10 cycles apart; done in cycle 31 after accept; position=+3 (with macro).
- cmd_steps=2, cmd_period=2, cmd_dir=0 -> period clamped to 5; pulses 5 cycles apart; position=−2 (with macro).
- cmd_steps=0 -> no step pulse; done in cycle 1 after accept; dir updated.
- cmd_steps=100, cmd_period=8; abort in cycle 20 of RUN -> step=0 and done in cycle 21; steps_left=98.
- Reset asserted at cycle 15 of a 5-step move -> all outputs 0 next edge, no done pulse; a new command is accepted normally afterwards.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: step/dir pulse sequencer for one joint (valid/ready move command, abort, done pulse).
// Define STEP_SEQ_POSITION_EN to build the signed step position accumulator; otherwise position is 0.
module step_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int STEP_WIDTH  = 16,
  parameter int PULSE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_dir,
  input  logic [STEP_WIDTH-1:0]  cmd_steps,
  input  logic [CNT_WIDTH-1:0]   cmd_period,
  input  logic                   abort,
  output logic                   step,
  output logic                   dir,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  steps_left,
  output logic signed [31:0]     position
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(PULSE_WIDTH + 1);
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, period, period_n;
  logic [STEP_WIDTH-1:0] steps_left_n;
  logic dir_n, accept, wrap, last;
  assign cmd_ready = state == IDLE && !reset;
  assign accept = cmd_valid && cmd_ready;
  assign wrap = state == RUN && cnt == period - CNT_WIDTH'(1);
  assign last = wrap && steps_left == STEP_WIDTH'(1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    period_n = period;
    steps_left_n = steps_left;
    dir_n = dir;
    case (state)
      IDLE: if (accept) begin
        dir_n = cmd_dir;
        steps_left_n = cmd_steps;
        period_n = cmd_period < MIN_P ? MIN_P : cmd_period;
        cnt_n = '0;
        state_n = cmd_steps == '0 ? DONE : RUN;
      end
      // final wrap wins over a coincident abort so the move reports zero remaining
      RUN: if (last) begin
        steps_left_n = '0;
        state_n = DONE;
      end else if (abort) begin
        state_n = DONE;
      end else if (wrap) begin
        cnt_n = '0;
        steps_left_n = steps_left - STEP_WIDTH'(1);
      end else begin
        cnt_n = cnt + CNT_WIDTH'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      period <= '0;
      steps_left <= '0;
      dir <= 1'b0;
      step <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      period <= period_n;
      steps_left <= steps_left_n;
      dir <= dir_n;
      step <= state_n == RUN && cnt_n < CNT_WIDTH'(PULSE_WIDTH);
      busy <= state_n != IDLE;
      done <= state_n == DONE;
    end
`ifdef STEP_SEQ_POSITION_EN
  logic rise;
  logic signed [31:0] pos;
  assign rise = state_n == RUN && cnt_n == '0;
  assign position = pos;
  always_ff @(posedge clk)
    if (reset) pos <= '0;
    else if (rise) pos <= pos + (dir_n ? 32'sd1 : -32'sd1);
`else
  assign position = '0;
`endif
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: timeline model of each move checked every cycle, plus directed literal checks.
module tb_step_sequencer;
  localparam int PW = 4;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [31:0] cmd_period = '0;
  logic step, dir, busy, done;
  logic [15:0] steps_left;
  logic signed [31:0] position;
  int pass_cnt = 0, total = 0;
  bit chk_en = 0;

  step_sequencer #(.CNT_WIDTH(32), .STEP_WIDTH(16), .PULSE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .step(step), .dir(dir),
    .busy(busy), .done(done), .steps_left(steps_left), .position(position));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
  endtask

  // Move timeline model: t counts cycles since acceptance, the move ends with done at t == end_t.
  bit act = 0, mdir = 0;
  int t = 0, n = 0, p = 0, end_t = 0, left_end = 0, sgn = 0;
  longint pos0 = 0, pos_end = 0;

  always @(negedge clk) if (chk_en) begin
    bit e_step, e_busy, e_done, e_ready;
    longint e_left, e_pos;
    if (act && t < end_t) begin
      e_step = ((t - 1) % p) < PW;
      e_busy = 1; e_done = 0;
      e_left = n - (t - 1) / p;
      e_pos = pos0 + sgn * ((t - 1) / p + 1);
    end else begin
      e_step = 0; e_busy = act; e_done = act;
      e_left = left_end; e_pos = pos_end;
    end
    e_ready = !act && !reset;
`ifndef STEP_SEQ_POSITION_EN
    e_pos = 0;
`endif
    chk("step", step, e_step);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("cmd_ready", cmd_ready, e_ready);
    chk("steps_left", steps_left, e_left);
    chk("dir", dir, mdir);
    chk("position", position, e_pos);
    if (reset) begin
      act = 0; mdir = 0; left_end = 0; pos_end = 0;
    end else if (act) begin
      if (t < end_t && t != n * p && abort) begin
        end_t = t + 1;
        left_end = n - (t - 1) / p;
        pos_end = pos0 + sgn * ((t - 1) / p + 1);
      end
      t++;
      if (t > end_t) act = 0;
    end else if (cmd_valid) begin
      act = 1; t = 1;
      n = int'(cmd_steps);
      p = cmd_period < PW + 1 ? PW + 1 : int'(cmd_period);
      mdir = cmd_dir; sgn = cmd_dir ? 1 : -1;
      end_t = n * p + 1; left_end = 0;
      pos0 = pos_end; pos_end = pos0 + sgn * n;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns in cycle 1 of the accepted move.
  task automatic send(input bit d, input int s, input int per);
    int g = 0;
    cmd_dir = d; cmd_steps = 16'(s); cmd_period = 32'(per); cmd_valid = 1;
    while (!cmd_ready && g < 1000) begin tick(); g++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    tick();
    cmd_valid = 0; cmd_steps = 16'hdead; cmd_period = 32'd3; cmd_dir = ~d;
  endtask

  // Runs to the done pulse, reporting its cycle index, rising-edge count, high cycles and last rise.
  task automatic run_to_done(output int c, output int rises, output int highs, output int last_rise);
    bit prev = 0;
    c = 1; rises = 0; highs = 0; last_rise = 0;
    while (!done && c < 5000) begin
      if (step && !prev) begin rises++; last_rise = c; end
      if (step) highs++;
      prev = step;
      tick(); c++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int c, r, h, lr;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    tick();
    reset = 0;
    repeat (5) tick();
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", steps_left, 0);
    chk("rst_ready", cmd_ready, 1);
    send(1, 3, 10);
    chk("m1_first_step", step, 1);
    run_to_done(c, r, h, lr);
    chk("m1_done_cycle", c, 31);
    chk("m1_rises", r, 3);
    chk("m1_highs", h, 12);
    chk("m1_last_rise", lr, 21);
`ifdef STEP_SEQ_POSITION_EN
    chk("m1_pos", position, 3);
`endif
    tick();
    chk("m1_ready_after", cmd_ready, 1);
    send(0, 2, 2);
    run_to_done(c, r, h, lr);
    chk("m2_done_cycle", c, 11);
    chk("m2_rises", r, 2);
    chk("m2_last_rise", lr, 6);
`ifdef STEP_SEQ_POSITION_EN
    chk("m2_pos", position, 1);
`endif
    abort = 1; tick(); abort = 0;
    send(1, 0, 7);
    chk("zero_done", done, 1);
    chk("zero_step", step, 0);
    chk("zero_dir", dir, 1);
    tick();
    send(0, 100, 8);
    repeat (19) tick();
    abort = 1; tick(); abort = 0;
    chk("ab_done", done, 1);
    chk("ab_step", step, 0);
    chk("ab_left", steps_left, 98);
    tick();
    chk("ab_ready", cmd_ready, 1);
    send(1, 2, 6);
    repeat (11) tick();
    abort = 1; tick(); abort = 0;
    chk("abw_done", done, 1);
    chk("abw_left", steps_left, 0);
    tick();
    send(1, 5, 10);
    repeat (14) tick();
    reset = 1; tick(); reset = 0;
    chk("rm_step", step, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_pos", position, 0);
    repeat (5) tick();
    send(1, 2, 5);
    run_to_done(c, r, h, lr);
    chk("post_rst_done_cycle", c, 11);
    chk("post_rst_rises", r, 2);
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
